// File: rtl/cassette_pkg.sv
// cassette_pkg: shared recorder state type, leader byte and FSK tick thresholds
// Thresholds are derived from the clock rate: MIN = shortest legal period,
// THR = 0/1 decision point, GAP = silence that ends a block.
package cassette_pkg;
    typedef enum logic [1:0] {IDLE, HUNT, DATA} rec_state_t;
    localparam logic [7:0] LEADER_BYTE = 8'h55;
    function automatic int min_t(input int hz);
        return hz / 4800;
    endfunction
    function automatic int thr_t(input int hz);
        return hz / 1800;
    endfunction
    function automatic int gap_t(input int hz);
        return hz / 600;
    endfunction
endpackage

// File: rtl/fsk_period_detector.sv
// fsk_period_detector: measures cout rise-to-rise periods and classifies them as bits
// Ports: i_clk/i_rst_n clock and async active-low reset; i_cout raw cassette bit;
//        o_bit_valid/o_bit_val one-cycle decoded bit; o_gap one-cycle silence pulse.
module fsk_period_detector
    import cassette_pkg::*;
#(
    parameter int CLK_HZ = 28_000_000
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cout,
    output logic o_bit_valid,
    output logic o_bit_val,
    output logic o_gap
);
    localparam int GAP = gap_t(CLK_HZ);
    localparam int CW = $clog2(GAP + 1);
    localparam logic [CW-1:0] MIN_C = CW'(min_t(CLK_HZ));
    localparam logic [CW-1:0] THR_C = CW'(thr_t(CLK_HZ));
    localparam logic [CW-1:0] GAP_C = CW'(GAP);
    logic r_s1, r_s2;
    logic [CW-1:0] r_cnt;
    logic w_rise;
    assign w_rise = r_s1 & ~r_s2;
    // rises arriving too soon after the last accepted edge are glitches and leave cnt running
    assign o_bit_valid = w_rise & (r_cnt >= MIN_C);
    assign o_bit_val = r_cnt < THR_C;
    // fires on the single cycle the saturating counter steps onto GAP
    assign o_gap = (r_cnt == GAP_C - 1'b1) & ~o_bit_valid;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_cout;
            r_s2 <= r_s1;
            r_cnt <= o_bit_valid ? CW'(1) : (r_cnt == GAP_C) ? r_cnt : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cassette_recorder.sv
// cassette_recorder: decodes MC-10 cassette FSK, aligns on leader 0x55 and writes bytes to SDRAM
// Ports: i_clk_sys/i_reset_n clock and async active-low reset; i_rec record level;
//        i_cout cassette bit; o_wr_req/i_wr_ack/o_wr_addr/o_wr_data SDRAM write port;
//        o_length committed bytes; o_status {overflow, full, locked}.
module cassette_recorder
    import cassette_pkg::*;
#(
    parameter int CLK_HZ  = 28_000_000,
    parameter int ADDR_W  = 25,
    parameter int MAX_LEN = 32768
)(
    input  logic              i_clk_sys,
    input  logic              i_reset_n,
    input  logic              i_rec,
    input  logic              i_cout,
    output logic              o_wr_req,
    input  logic              i_wr_ack,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic [ADDR_W-1:0] o_length,
    output logic [2:0]        o_status
);
    localparam logic [ADDR_W-1:0] MAX_C = ADDR_W'(MAX_LEN);
    rec_state_t r_state, w_next;
    logic r_rec_d, r_locked, r_full, r_ovf, r_req;
    logic [7:0] r_shreg, r_data;
    logic [2:0] r_bitcnt;
    logic [ADDR_W-1:0] r_addr, r_len;
    logic w_bit_valid, w_bit_val, w_gap, w_rec_rise, w_lock, w_emit;
    logic [7:0] w_sh;

    fsk_period_detector #(.CLK_HZ(CLK_HZ)) u_det (
        .i_clk(i_clk_sys),
        .i_rst_n(i_reset_n),
        .i_cout(i_cout),
        .o_bit_valid(w_bit_valid),
        .o_bit_val(w_bit_val),
        .o_gap(w_gap)
    );

    assign w_rec_rise = i_rec & ~r_rec_d;
    assign w_sh = {w_bit_val, r_shreg[7:1]};
    assign o_wr_req = r_req;
    assign o_wr_addr = r_addr;
    assign o_wr_data = r_data;
    assign o_length = r_len;
    assign o_status = {r_ovf, r_full, r_locked};

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = !i_rec ? IDLE : w_rec_rise ? HUNT : w_lock ? DATA : (r_state == DATA && w_gap) ? HUNT : r_state;
    end

    // the byte that completes the leader pattern is itself the first byte stored
    always_comb begin
        w_lock = i_rec & (r_state == HUNT) & w_bit_valid & (w_sh == LEADER_BYTE);
        w_emit = w_lock | (i_rec & (r_state == DATA) & w_bit_valid & (r_bitcnt == 3'd7));
    end

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rec_d <= 1'b0;
            r_shreg <= '0;
            r_bitcnt <= '0;
            r_locked <= 1'b0;
            r_full <= 1'b0;
            r_ovf <= 1'b0;
            r_req <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_len <= '0;
        end else begin
            r_rec_d <= i_rec;
            if (w_rec_rise) begin
                // a new recording wins over any in-flight handshake, which is abandoned
                r_shreg <= '0;
                r_bitcnt <= '0;
                r_locked <= 1'b0;
                r_full <= 1'b0;
                r_ovf <= 1'b0;
                r_req <= 1'b0;
                r_addr <= '0;
                r_len <= '0;
            end else begin
                if (w_bit_valid && r_state != IDLE) r_shreg <= w_sh;
                r_bitcnt <= (w_lock || (r_state == DATA && w_gap)) ? 3'd0 :
                            (r_state == DATA && w_bit_valid) ? r_bitcnt + 3'd1 : r_bitcnt;
                r_locked <= i_rec & (w_lock | (r_locked & ~((r_state == DATA) & w_gap)));
                if (r_req && i_wr_ack) begin
                    r_req <= 1'b0;
                    r_addr <= r_addr + 1'b1;
                    r_len <= r_len + 1'b1;
                end
                if (w_emit) begin
                    if (r_len == MAX_C) r_full <= 1'b1;
                    else if (r_req) r_ovf <= 1'b1;
                    else begin
                        r_data <= w_sh;
                        r_req <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cassette_recorder.sv
// tb_cassette_recorder: directed checks of FSK capture, framing and SDRAM write port
`timescale 1ns/1ps
module tb_cassette_recorder;
    localparam int HZ = 96_000;
    localparam int P0 = HZ / 1200;
    localparam int P1 = HZ / 2400;
    localparam int AW = 25;
    logic clk = 1'b0;
    logic reset_n = 1'b0, rec = 1'b0, rec4 = 1'b0, cout = 1'b0;
    logic ack_en = 1'b1, ack_force = 1'b0, glitch = 1'b0;
    logic wr_req, wr_ack, wr_req4, wr_ack4;
    logic [AW-1:0] wr_addr, length, wr_addr4, length4;
    logic [7:0] wr_data, wr_data4;
    logic [2:0] status, status4;
    logic [AW-1:0] la [0:127];
    logic [7:0] ld [0:127];
    int nwr = 0, nwr4 = 0, total = 0, bad = 0;

    always #5 clk = ~clk;
    assign wr_ack = (ack_en & wr_req) | ack_force;
    assign wr_ack4 = wr_req4;

    cassette_recorder #(.CLK_HZ(HZ), .ADDR_W(AW), .MAX_LEN(32768)) dut (
        .i_clk_sys(clk), .i_reset_n(reset_n), .i_rec(rec), .i_cout(cout),
        .o_wr_req(wr_req), .i_wr_ack(wr_ack), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_length(length), .o_status(status)
    );

    cassette_recorder #(.CLK_HZ(HZ), .ADDR_W(AW), .MAX_LEN(4)) dut4 (
        .i_clk_sys(clk), .i_reset_n(reset_n), .i_rec(rec4), .i_cout(cout),
        .o_wr_req(wr_req4), .i_wr_ack(wr_ack4), .o_wr_addr(wr_addr4), .o_wr_data(wr_data4),
        .o_length(length4), .o_status(status4)
    );

    always @(posedge clk) begin
        if (wr_req && wr_ack && nwr < 128) begin
            la[nwr] <= wr_addr;
            ld[nwr] <= wr_data;
            nwr <= nwr + 1;
        end
        if (wr_req4 && wr_ack4) nwr4 <= nwr4 + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int p);
        cout = 1'b1;
        if (glitch) begin
            idle(5);
            cout = 1'b0;
            idle(5);
            cout = 1'b1;
            idle(p / 2 - 10);
        end else idle(p / 2);
        cout = 1'b0;
        idle(p - p / 2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) pulse(b[i] ? P1 : P0);
    endtask

    task automatic start_rec;
        idle(200);
        rec = 1'b0;
        idle(4);
        rec = 1'b1;
        idle(2);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle(3);
        total++;
        if ({wr_req, wr_addr, wr_data, length, status} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b addr=%0d data=%h len=%0d st=%b, want all 0", wr_req, wr_addr, wr_data, length, status);
        end
        total++;
        if ({wr_req4, wr_addr4, wr_data4, length4, status4} !== '0) begin
            bad++;
            $display("FAIL reset_outputs4: req=%b addr=%0d len=%0d st=%b, want all 0", wr_req4, wr_addr4, length4, status4);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_leader;
        int base;
        logic [7:0] e;
        base = nwr;
        start_rec;
        send_byte(8'h55);
        total++;
        if (status !== 3'b000) begin bad++; $display("FAIL lock_early: st=%b want 000", status); end
        send_byte(8'h55);
        total++;
        if (status !== 3'b001) begin bad++; $display("FAIL lock_leader: st=%b want 001", status); end
        for (int i = 2; i < 40; i++) send_byte(8'h55);
        send_byte(8'h3C);
        send_byte(8'hA5);
        pulse(P0);
        total++;
        if (nwr - base != 42) begin bad++; $display("FAIL leader_writes: got %0d want 42", nwr - base); end
        total++;
        if (length !== AW'(42)) begin bad++; $display("FAIL leader_length: got %0d want 42", length); end
        for (int i = 0; i < 42; i++) begin
            e = (i == 40) ? 8'h3C : (i == 41) ? 8'hA5 : 8'h55;
            total++;
            if (la[base+i] !== AW'(i) || ld[base+i] !== e) begin
                bad++;
                $display("FAIL leader_byte%0d: addr=%0d data=%h want addr=%0d data=%h", i, la[base+i], ld[base+i], i, e);
            end
        end
    endtask

    task automatic test_backpressure;
        int base;
        base = nwr;
        ack_en = 1'b0;
        start_rec;
        send_byte(8'h55);
        send_byte(8'h11);
        send_byte(8'h22);
        total++;
        if (wr_req !== 1'b1 || wr_addr !== AW'(0) || wr_data !== 8'h55 || status !== 3'b101) begin
            bad++;
            $display("FAIL bp_hold1: req=%b addr=%0d data=%h st=%b want 1 0 55 101", wr_req, wr_addr, wr_data, status);
        end
        send_byte(8'h33);
        total++;
        if (wr_req !== 1'b1 || wr_addr !== AW'(0) || wr_data !== 8'h55) begin
            bad++;
            $display("FAIL bp_hold2: req=%b addr=%0d data=%h want 1 0 55", wr_req, wr_addr, wr_data);
        end
        ack_en = 1'b1;
        send_byte(8'h44);
        pulse(P0);
        total++;
        if (nwr - base != 3 || length !== AW'(3)) begin
            bad++;
            $display("FAIL bp_count: writes=%0d len=%0d want 3 3", nwr - base, length);
        end
        total++;
        if (la[base] !== AW'(0) || ld[base] !== 8'h55 || la[base+1] !== AW'(1) || ld[base+1] !== 8'h33 ||
            la[base+2] !== AW'(2) || ld[base+2] !== 8'h44) begin
            bad++;
            $display("FAIL bp_data: %0d:%h %0d:%h %0d:%h want 0:55 1:33 2:44",
                     la[base], ld[base], la[base+1], ld[base+1], la[base+2], ld[base+2]);
        end
    endtask

    task automatic test_gap;
        int base;
        base = nwr;
        start_rec;
        send_byte(8'h55);
        send_byte(8'h12);
        repeat (3) pulse(P0);
        idle(320);
        total++;
        if (status !== 3'b000 || nwr - base != 2 || length !== AW'(2)) begin
            bad++;
            $display("FAIL gap_unlock: st=%b writes=%0d len=%0d want 000 2 2", status, nwr - base, length);
        end
        send_byte(8'h55);
        pulse(P0);
        total++;
        if (status !== 3'b001 || nwr - base != 3 || la[base+2] !== AW'(2) || ld[base+2] !== 8'h55) begin
            bad++;
            $display("FAIL gap_relock: st=%b writes=%0d addr=%0d data=%h want 001 3 2 55",
                     status, nwr - base, la[base+2], ld[base+2]);
        end
    endtask

    task automatic test_glitch;
        int base;
        base = nwr;
        glitch = 1'b1;
        start_rec;
        send_byte(8'h55);
        send_byte(8'h3C);
        send_byte(8'hA5);
        pulse(P0);
        glitch = 1'b0;
        total++;
        if (nwr - base != 3 || la[base] !== AW'(0) || ld[base] !== 8'h55 || la[base+1] !== AW'(1) ||
            ld[base+1] !== 8'h3C || la[base+2] !== AW'(2) || ld[base+2] !== 8'hA5) begin
            bad++;
            $display("FAIL glitch_data: writes=%0d %h %h %h want 3 55 3C A5", nwr - base, ld[base], ld[base+1], ld[base+2]);
        end
    endtask

    task automatic test_full;
        int base4;
        base4 = nwr4;
        rec = 1'b0;
        idle(200);
        rec4 = 1'b1;
        idle(2);
        send_byte(8'h55);
        for (int i = 1; i < 6; i++) send_byte(8'(i));
        pulse(P0);
        total++;
        if (nwr4 - base4 != 4) begin bad++; $display("FAIL full_writes: got %0d want 4", nwr4 - base4); end
        total++;
        if (length4 !== AW'(4) || wr_addr4 !== AW'(4)) begin
            bad++;
            $display("FAIL full_length: len=%0d addr=%0d want 4 4", length4, wr_addr4);
        end
        total++;
        if (status4[2:1] !== 2'b01) begin bad++; $display("FAIL full_flags: ovf,full=%b want 01", status4[2:1]); end
        rec4 = 1'b0;
    endtask

    task automatic test_rec_ack;
        start_rec;
        send_byte(8'h55);
        send_byte(8'h11);
        send_byte(8'h22);
        ack_en = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        total++;
        if (wr_req !== 1'b1 || wr_addr !== AW'(2) || length !== AW'(2) || status !== 3'b101) begin
            bad++;
            $display("FAIL recack_pre: req=%b addr=%0d len=%0d st=%b want 1 2 2 101", wr_req, wr_addr, length, status);
        end
        rec = 1'b0;
        idle(1);
        rec = 1'b1;
        ack_force = 1'b1;
        idle(1);
        ack_force = 1'b0;
        total++;
        if (wr_addr !== AW'(0) || length !== AW'(0) || status !== 3'b000) begin
            bad++;
            $display("FAIL recack_clear: addr=%0d len=%0d st=%b want 0 0 000", wr_addr, length, status);
        end
    endtask

    task automatic test_async_reset;
        ack_en = 1'b0;
        start_rec;
        send_byte(8'h55);
        pulse(P0);
        total++;
        if (wr_req !== 1'b1 || wr_data !== 8'h55) begin
            bad++;
            $display("FAIL areset_pre: req=%b data=%h want 1 55", wr_req, wr_data);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({wr_req, wr_addr, wr_data, length, status} !== '0 || length4 !== '0) begin
            bad++;
            $display("FAIL areset_outputs: req=%b addr=%0d data=%h len=%0d st=%b len4=%0d want all 0",
                     wr_req, wr_addr, wr_data, length, status, length4);
        end
        idle(2);
        reset_n = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset;
        test_leader;
        test_backpressure;
        test_gap;
        test_glitch;
        test_full;
        test_rec_ack;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
